// File: rtl/rollback_sequencer.sv
// Rollback recovery sequencer: picks the oldest rollback request, pulses a squash,
// walks the squashed ROB entries youngest-first, then holds a fetch redirect.
module rollback_sequencer #(
    parameter int NUM_ROB    = 32,
    parameter int NUM_REQ    = 4,
    parameter int WALK_WIDTH = 2,
    localparam int ROBW      = $clog2(NUM_ROB)
) (
    input  logic                       clock_i,
    input  logic                       reset_i,
    input  logic [NUM_REQ-1:0]         req_valid_i,
    input  logic [NUM_REQ*ROBW-1:0]    req_ROB_idx_i,
    input  logic [NUM_REQ*64-1:0]      req_target_PC_i,
    input  logic [ROBW-1:0]            ROB_tail_i,
    input  logic                       fetch_ready_i,
    output logic [NUM_REQ-1:0]         accept_o,
    output logic                       busy_o,
    output logic                       squash_en_o,
    output logic [ROBW-1:0]            squash_ROB_idx_o,
    output logic [WALK_WIDTH-1:0]      walk_valid_o,
    output logic [WALK_WIDTH*ROBW-1:0] walk_ROB_idx_o,
    output logic                       redirect_valid_o,
    output logic [63:0]                redirect_PC_o
);

    localparam int DW = ROBW + 1;

    typedef enum logic [1:0] {IDLE, WALK, REDIRECT} state_e;

    state_e                     state_q, state_d;
    logic [ROBW-1:0]            idx_q, idx_d;
    logic [63:0]                pc_q, pc_d;
    logic [DW-1:0]              dist_q, dist_d;
    logic [DW-1:0]              remain_q, remain_d;
    logic [ROBW-1:0]            walk_ptr_q, walk_ptr_d;

    logic                       squash_q, squash_d;
    logic [ROBW-1:0]            squash_idx_q, squash_idx_d;
    logic [WALK_WIDTH-1:0]      walk_valid_q, walk_valid_d;
    logic [WALK_WIDTH*ROBW-1:0] walk_idx_q, walk_idx_d;
    logic                       redirect_valid_q, redirect_valid_d;
    logic [63:0]                redirect_pc_q, redirect_pc_d;

    logic                       win_any;
    logic [NUM_REQ-1:0]         win_oh;
    logic [DW-1:0]              win_dist;
    logic [ROBW-1:0]            win_idx;
    logic [63:0]                win_pc;
    logic [ROBW-1:0]            diff;
    logic [DW-1:0]              age;
    logic                       grant;
    logic [DW-1:0]              lanes;
    logic [DW-1:0]              next_lanes;

    // Oldest request wins; a distance of zero means the whole ROB is behind the culprit.
    always_comb begin
        win_any  = 1'b0;
        win_oh   = '0;
        win_dist = '0;
        win_idx  = '0;
        win_pc   = '0;
        diff     = '0;
        age      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            diff = ROB_tail_i - req_ROB_idx_i[k*ROBW +: ROBW];
            age  = (diff == '0) ? DW'(NUM_ROB) : {1'b0, diff};
            if (req_valid_i[k] && (!win_any || age > win_dist)) begin
                win_any  = 1'b1;
                win_oh   = '0;
                win_oh[k] = 1'b1;
                win_dist = age;
                win_idx  = req_ROB_idx_i[k*ROBW +: ROBW];
                win_pc   = req_target_PC_i[k*64 +: 64];
            end
        end
    end

    // While busy only a strictly older culprit may take over the sequence.
    assign grant = win_any && (state_q == IDLE || win_dist > dist_q);
    assign lanes = (state_q != WALK) ? '0 :
                   (remain_q > DW'(WALK_WIDTH)) ? DW'(WALK_WIDTH) : remain_q;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q          <= IDLE;
            idx_q            <= '0;
            pc_q             <= '0;
            dist_q           <= '0;
            remain_q         <= '0;
            walk_ptr_q       <= '0;
            squash_q         <= 1'b0;
            squash_idx_q     <= '0;
            walk_valid_q     <= '0;
            walk_idx_q       <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            state_q          <= state_d;
            idx_q            <= idx_d;
            pc_q             <= pc_d;
            dist_q           <= dist_d;
            remain_q         <= remain_d;
            walk_ptr_q       <= walk_ptr_d;
            squash_q         <= squash_d;
            squash_idx_q     <= squash_idx_d;
            walk_valid_q     <= walk_valid_d;
            walk_idx_q       <= walk_idx_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        pc_d       = pc_q;
        dist_d     = dist_q;
        walk_ptr_d = walk_ptr_q - lanes[ROBW-1:0];
        remain_d   = remain_q - lanes;
        if (grant) begin
            idx_d  = win_idx;
            pc_d   = win_pc;
            dist_d = win_dist;
            if (state_q == IDLE) begin
                walk_ptr_d = ROB_tail_i - ROBW'(1);
                remain_d   = win_dist - DW'(1);
            end else begin
                // Preemption extends the walk by the extra distance; the pointer keeps going.
                remain_d = remain_q - lanes + (win_dist - dist_q);
            end
            state_d = (remain_d != '0) ? WALK : REDIRECT;
        end else begin
            case (state_q)
                WALK:     if (remain_d == '0) state_d = REDIRECT;
                REDIRECT: if (redirect_valid_q && fetch_ready_i) state_d = IDLE;
                default:  state_d = state_q;
            endcase
        end
    end

    // Registered outputs describe the state being entered at the next edge.
    always_comb begin
        squash_d     = grant;
        squash_idx_d = grant ? win_idx : squash_idx_q;
        next_lanes   = (state_d != WALK) ? '0 :
                       (remain_d > DW'(WALK_WIDTH)) ? DW'(WALK_WIDTH) : remain_d;
        walk_valid_d = '0;
        walk_idx_d   = '0;
        for (int i = 0; i < WALK_WIDTH; i++) begin
            walk_valid_d[i]               = (DW'(i) < next_lanes);
            walk_idx_d[i*ROBW +: ROBW]    = walk_ptr_d - ROBW'(i);
        end
        // The redirect waits until the cycle after any squash pulse.
        redirect_valid_d = (state_d == REDIRECT) && !grant;
        redirect_pc_d    = redirect_valid_d ? pc_d : redirect_pc_q;
    end

    assign accept_o         = grant ? win_oh : '0;
    assign busy_o           = (state_q != IDLE);
    assign squash_en_o      = squash_q;
    assign squash_ROB_idx_o = squash_idx_q;
    assign walk_valid_o     = walk_valid_q;
    assign walk_ROB_idx_o   = walk_idx_q;
    assign redirect_valid_o = redirect_valid_q;
    assign redirect_PC_o    = redirect_pc_q;

endmodule

// File: tb/tb_rollback_sequencer.sv
// Bench for rollback_sequencer: directed recovery scenarios plus a randomized run
// against a queue-based model of the entries still waiting to be undone.
module tb_rollback_sequencer;

    logic        clock_i = 1'b0;
    logic        reset_i;
    logic [3:0]  req_valid;
    logic [19:0] req_idx;
    logic [255:0] req_pc;
    logic [4:0]  tail;
    logic        fetch_ready;
    logic [3:0]  accept_o;
    logic        busy_o;
    logic        squash_en_o;
    logic [4:0]  squash_ROB_idx_o;
    logic [1:0]  walk_valid_o;
    logic [9:0]  walk_ROB_idx_o;
    logic        redirect_valid_o;
    logic [63:0] redirect_PC_o;
    logic [4:0]  obs;

    int n_chk  = 0;
    int n_pass = 0;

    rollback_sequencer #(.NUM_ROB(32), .NUM_REQ(4), .WALK_WIDTH(2)) dut (
        .clock_i          (clock_i),
        .reset_i          (reset_i),
        .req_valid_i      (req_valid),
        .req_ROB_idx_i    (req_idx),
        .req_target_PC_i  (req_pc),
        .ROB_tail_i       (tail),
        .fetch_ready_i    (fetch_ready),
        .accept_o         (accept_o),
        .busy_o           (busy_o),
        .squash_en_o      (squash_en_o),
        .squash_ROB_idx_o (squash_ROB_idx_o),
        .walk_valid_o     (walk_valid_o),
        .walk_ROB_idx_o   (walk_ROB_idx_o),
        .redirect_valid_o (redirect_valid_o),
        .redirect_PC_o    (redirect_PC_o)
    );

    always #5 clock_i = ~clock_i;

    // {busy, squash, walk_valid[1:0], redirect_valid}
    assign obs = {busy_o, squash_en_o, walk_valid_o, redirect_valid_o};

    task automatic tick();
        @(posedge clock_i);
        #1;
    endtask

    task automatic set_req(input int k, input logic [4:0] idx, input logic [63:0] pc);
        req_valid[k]        = 1'b1;
        req_idx[k*5 +: 5]   = idx;
        req_pc[k*64 +: 64]  = pc;
    endtask

    task automatic clr_req();
        req_valid = '0;
    endtask

    task automatic test_reset();
        #2 reset_i = 1'b1;
        #1;
        n_chk++; if (obs !== 5'b0) $display("FAIL reset_ctrl got %b want %b", obs, 5'b0); else n_pass++;
        n_chk++; if (accept_o !== 4'b0) $display("FAIL reset_accept got %b want 0", accept_o); else n_pass++;
        n_chk++; if (squash_ROB_idx_o !== 5'd0) $display("FAIL reset_sqidx got %0d want 0", squash_ROB_idx_o); else n_pass++;
        n_chk++; if (walk_ROB_idx_o !== 10'd0) $display("FAIL reset_walkidx got %h want 0", walk_ROB_idx_o); else n_pass++;
        n_chk++; if (redirect_PC_o !== 64'd0) $display("FAIL reset_pc got %h want 0", redirect_PC_o); else n_pass++;
        tick();
        reset_i = 1'b0;
        tick();
    endtask

    task automatic test_basic_walk();
        tail = 5'd10; set_req(0, 5'd5, 64'h400); #1;
        n_chk++; if (accept_o !== 4'b0001) $display("FAIL t1_accept got %b want 0001", accept_o); else n_pass++;
        n_chk++; if (busy_o !== 1'b0) $display("FAIL t1_idle_busy got %b want 0", busy_o); else n_pass++;
        tick(); clr_req(); #1;
        n_chk++; if (obs !== 5'b11110) $display("FAIL t1_c1 got %b want 11110", obs); else n_pass++;
        n_chk++; if (squash_ROB_idx_o !== 5'd5) $display("FAIL t1_sqidx got %0d want 5", squash_ROB_idx_o); else n_pass++;
        n_chk++; if (walk_ROB_idx_o !== {5'd8, 5'd9}) $display("FAIL t1_walk1 got %h want %h", walk_ROB_idx_o, {5'd8, 5'd9}); else n_pass++;
        tick(); #1;
        n_chk++; if (obs !== 5'b10110) $display("FAIL t1_c2 got %b want 10110", obs); else n_pass++;
        n_chk++; if (walk_ROB_idx_o !== {5'd6, 5'd7}) $display("FAIL t1_walk2 got %h want %h", walk_ROB_idx_o, {5'd6, 5'd7}); else n_pass++;
        tick(); #1;
        n_chk++; if (obs !== 5'b10001) $display("FAIL t1_redir got %b want 10001", obs); else n_pass++;
        n_chk++; if (redirect_PC_o !== 64'h400) $display("FAIL t1_pc got %h want 400", redirect_PC_o); else n_pass++;
        fetch_ready = 1'b1;
        tick(); fetch_ready = 1'b0; #1;
        n_chk++; if (obs !== 5'b00000) $display("FAIL t1_idle got %b want 00000", obs); else n_pass++;
    endtask

    task automatic test_arbitration();
        tail = 5'd10; set_req(1, 5'd7, 64'h1111); set_req(3, 5'd4, 64'h3333); #1;
        n_chk++; if (accept_o !== 4'b1000) $display("FAIL t2_accept got %b want 1000", accept_o); else n_pass++;
        tick(); clr_req(); #1;
        n_chk++; if (obs !== 5'b11110) $display("FAIL t2_c1 got %b want 11110", obs); else n_pass++;
        n_chk++; if (squash_ROB_idx_o !== 5'd4) $display("FAIL t2_sqidx got %0d want 4", squash_ROB_idx_o); else n_pass++;
        n_chk++; if (walk_ROB_idx_o !== {5'd8, 5'd9}) $display("FAIL t2_walk1 got %h want %h", walk_ROB_idx_o, {5'd8, 5'd9}); else n_pass++;
        tick(); #1;
        n_chk++; if (walk_ROB_idx_o !== {5'd6, 5'd7}) $display("FAIL t2_walk2 got %h want %h", walk_ROB_idx_o, {5'd6, 5'd7}); else n_pass++;
        tick(); #1;
        n_chk++; if (obs !== 5'b10010) $display("FAIL t2_c3 got %b want 10010", obs); else n_pass++;
        n_chk++; if (walk_ROB_idx_o[4:0] !== 5'd5) $display("FAIL t2_walk3 got %0d want 5", walk_ROB_idx_o[4:0]); else n_pass++;
        tick(); #1;
        n_chk++; if (redirect_PC_o !== 64'h3333 || obs !== 5'b10001) $display("FAIL t2_redir got %b/%h want 10001/3333", obs, redirect_PC_o); else n_pass++;
        fetch_ready = 1'b1; tick(); fetch_ready = 1'b0; #1;
        n_chk++; if (obs !== 5'b00000) $display("FAIL t2_idle got %b want 00000", obs); else n_pass++;
    endtask

    task automatic test_wrap();
        tail = 5'd2; set_req(2, 5'd30, 64'h2222); #1;
        n_chk++; if (accept_o !== 4'b0100) $display("FAIL t3_accept got %b want 0100", accept_o); else n_pass++;
        tick(); clr_req(); #1;
        n_chk++; if (walk_ROB_idx_o !== {5'd0, 5'd1} || obs !== 5'b11110) $display("FAIL t3_walk1 got %b/%h want 11110/%h", obs, walk_ROB_idx_o, {5'd0, 5'd1}); else n_pass++;
        tick(); #1;
        n_chk++; if (walk_ROB_idx_o[4:0] !== 5'd31 || obs !== 5'b10010) $display("FAIL t3_walk2 got %b/%0d want 10010/31", obs, walk_ROB_idx_o[4:0]); else n_pass++;
        tick(); #1;
        n_chk++; if (redirect_PC_o !== 64'h2222 || obs !== 5'b10001) $display("FAIL t3_redir got %b/%h want 10001/2222", obs, redirect_PC_o); else n_pass++;
        fetch_ready = 1'b1; tick(); fetch_ready = 1'b0; #1;
    endtask

    task automatic test_preempt_walk();
        tail = 5'd20; set_req(0, 5'd15, 64'hA000); #1;
        n_chk++; if (accept_o !== 4'b0001) $display("FAIL t4_accept0 got %b want 0001", accept_o); else n_pass++;
        tick(); clr_req(); #1;
        n_chk++; if (walk_ROB_idx_o !== {5'd18, 5'd19}) $display("FAIL t4_walk1 got %h want %h", walk_ROB_idx_o, {5'd18, 5'd19}); else n_pass++;
        tick(); set_req(1, 5'd12, 64'hB000); #1;
        n_chk++; if (accept_o !== 4'b0010) $display("FAIL t4_accept1 got %b want 0010", accept_o); else n_pass++;
        n_chk++; if (obs !== 5'b10110 || walk_ROB_idx_o !== {5'd16, 5'd17}) $display("FAIL t4_walk2 got %b/%h want 10110/%h", obs, walk_ROB_idx_o, {5'd16, 5'd17}); else n_pass++;
        tick(); clr_req(); set_req(0, 5'd15, 64'hA000); #1;
        n_chk++; if (accept_o !== 4'b0000) $display("FAIL t4_ignore got %b want 0000", accept_o); else n_pass++;
        n_chk++; if (obs !== 5'b11110 || squash_ROB_idx_o !== 5'd12) $display("FAIL t4_squash2 got %b/%0d want 11110/12", obs, squash_ROB_idx_o); else n_pass++;
        n_chk++; if (walk_ROB_idx_o !== {5'd14, 5'd15}) $display("FAIL t4_walk3 got %h want %h", walk_ROB_idx_o, {5'd14, 5'd15}); else n_pass++;
        tick(); clr_req(); #1;
        n_chk++; if (obs !== 5'b10010 || walk_ROB_idx_o[4:0] !== 5'd13) $display("FAIL t4_walk4 got %b/%0d want 10010/13", obs, walk_ROB_idx_o[4:0]); else n_pass++;
        tick(); #1;
        n_chk++; if (redirect_PC_o !== 64'hB000 || obs !== 5'b10001) $display("FAIL t4_redir got %b/%h want 10001/b000", obs, redirect_PC_o); else n_pass++;
        fetch_ready = 1'b1; tick(); fetch_ready = 1'b0; #1;
    endtask

    task automatic test_redirect_hold_preempt();
        tail = 5'd20; set_req(0, 5'd18, 64'hC000); #1;
        tick(); clr_req(); #1;
        n_chk++; if (obs !== 5'b11010 || walk_ROB_idx_o[4:0] !== 5'd19) $display("FAIL t5_walk got %b/%0d want 11010/19", obs, walk_ROB_idx_o[4:0]); else n_pass++;
        for (int c = 0; c < 3; c++) begin
            tick(); #1;
            n_chk++; if (obs !== 5'b10001 || redirect_PC_o !== 64'hC000) $display("FAIL t5_hold%0d got %b/%h want 10001/c000", c, obs, redirect_PC_o); else n_pass++;
        end
        set_req(1, 5'd16, 64'hD000); fetch_ready = 1'b1; #1;
        n_chk++; if (accept_o !== 4'b0010) $display("FAIL t5_accept got %b want 0010", accept_o); else n_pass++;
        tick(); clr_req(); fetch_ready = 1'b0; #1;
        n_chk++; if (obs !== 5'b11110 || squash_ROB_idx_o !== 5'd16) $display("FAIL t5_back got %b/%0d want 11110/16", obs, squash_ROB_idx_o); else n_pass++;
        n_chk++; if (walk_ROB_idx_o !== {5'd17, 5'd18}) $display("FAIL t5_walk2 got %h want %h", walk_ROB_idx_o, {5'd17, 5'd18}); else n_pass++;
        tick(); #1;
        n_chk++; if (obs !== 5'b10001 || redirect_PC_o !== 64'hD000) $display("FAIL t5_redir got %b/%h want 10001/d000", obs, redirect_PC_o); else n_pass++;
        fetch_ready = 1'b1; tick(); fetch_ready = 1'b0; #1;
        n_chk++; if (obs !== 5'b00000) $display("FAIL t5_idle got %b want 00000", obs); else n_pass++;
    endtask

    task automatic test_no_walk_and_async_reset();
        tail = 5'd9; set_req(0, 5'd8, 64'hE000); #1;
        tick(); clr_req(); fetch_ready = 1'b1; #1;
        n_chk++; if (obs !== 5'b11000 || squash_ROB_idx_o !== 5'd8) $display("FAIL t6_squash got %b/%0d want 11000/8", obs, squash_ROB_idx_o); else n_pass++;
        tick(); #1;
        n_chk++; if (obs !== 5'b10001 || redirect_PC_o !== 64'hE000) $display("FAIL t6_redir got %b/%h want 10001/e000", obs, redirect_PC_o); else n_pass++;
        tick(); fetch_ready = 1'b0; #1;
        n_chk++; if (obs !== 5'b00000) $display("FAIL t6_idle got %b want 00000", obs); else n_pass++;
        tail = 5'd10; set_req(3, 5'd0, 64'hF000); #1;
        tick(); clr_req(); #1;
        n_chk++; if (obs !== 5'b11110) $display("FAIL t6_walk got %b want 11110", obs); else n_pass++;
        #1 reset_i = 1'b1; #1;
        n_chk++; if (obs !== 5'b00000) $display("FAIL t6_areset_ctrl got %b want 00000", obs); else n_pass++;
        n_chk++; if (walk_ROB_idx_o !== 10'd0 || squash_ROB_idx_o !== 5'd0 || redirect_PC_o !== 64'd0) $display("FAIL t6_areset_data got %h/%0d/%h want 0/0/0", walk_ROB_idx_o, squash_ROB_idx_o, redirect_PC_o); else n_pass++;
        tick(); reset_i = 1'b0; tick();
    endtask

    task automatic test_full_rob();
        int total = 0;
        int last  = -1;
        int cyc   = 0;
        tail = 5'd5; set_req(2, 5'd5, 64'hF00D); #1;
        n_chk++; if (accept_o !== 4'b0100) $display("FAIL full_accept got %b want 0100", accept_o); else n_pass++;
        tick(); clr_req(); #1;
        while (walk_valid_o != 2'b00 && cyc < 40) begin
            for (int j = 0; j < 2; j++)
                if (walk_valid_o[j]) begin total++; last = int'(walk_ROB_idx_o[j*5 +: 5]); end
            cyc++;
            tick(); #1;
        end
        n_chk++; if (total != 31) $display("FAIL full_count got %0d want 31", total); else n_pass++;
        n_chk++; if (last != 6) $display("FAIL full_last got %0d want 6", last); else n_pass++;
        n_chk++; if (cyc != 16) $display("FAIL full_cycles got %0d want 16", cyc); else n_pass++;
        n_chk++; if (obs !== 5'b10001 || redirect_PC_o !== 64'hF00D) $display("FAIL full_redir got %b/%h want 10001/f00d", obs, redirect_PC_o); else n_pass++;
        fetch_ready = 1'b1; tick(); fetch_ready = 1'b0; #1;
    endtask

    task automatic test_random();
        int mode, cul, age_cur, sq_idx, best, best_age, a;
        int q[$];
        int shown[$];
        bit sq, rv, take;
        logic [63:0] mpc, rpc;
        logic [3:0] exp_acc;
        logic [1:0] exp_wv;
        reset_i = 1'b1; tick(); reset_i = 1'b0;
        mode = 0; cul = 0; age_cur = 0; sq_idx = 0; sq = 0; rv = 0; mpc = '0; rpc = '0;
        for (int c = 0; c < 400; c++) begin
            clr_req();
            for (int k = 0; k < 4; k++)
                if ($urandom_range(0, 5) == 0) set_req(k, 5'($urandom_range(0, 31)), {$urandom, $urandom});
            if (mode == 0) tail = 5'($urandom_range(0, 31));
            fetch_ready = 1'($urandom_range(0, 1));
            best = -1; best_age = 0;
            for (int k = 0; k < 4; k++)
                if (req_valid[k]) begin
                    a = (int'(tail) - int'(req_idx[k*5 +: 5]) + 32) % 32;
                    if (a == 0) a = 32;
                    if (a > best_age) begin best = k; best_age = a; end
                end
            take = (best >= 0) && (mode == 0 || best_age > age_cur);
            exp_acc = take ? 4'(1 << best) : 4'b0000;
            exp_wv  = 2'((1 << shown.size()) - 1);
            #1;
            n_chk++; if (accept_o !== exp_acc) $display("FAIL rnd_accept c%0d got %b want %b", c, accept_o, exp_acc); else n_pass++;
            n_chk++; if ({busy_o, squash_en_o, redirect_valid_o} !== {mode != 0, sq, rv}) $display("FAIL rnd_ctrl c%0d got %b want %b", c, {busy_o, squash_en_o, redirect_valid_o}, {mode != 0, sq, rv}); else n_pass++;
            n_chk++; if (walk_valid_o !== exp_wv) $display("FAIL rnd_wvalid c%0d got %b want %b", c, walk_valid_o, exp_wv); else n_pass++;
            if (sq) begin
                n_chk++; if (squash_ROB_idx_o !== 5'(sq_idx)) $display("FAIL rnd_sqidx c%0d got %0d want %0d", c, squash_ROB_idx_o, sq_idx); else n_pass++;
            end
            for (int j = 0; j < shown.size(); j++) begin
                n_chk++; if (walk_ROB_idx_o[j*5 +: 5] !== 5'(shown[j])) $display("FAIL rnd_walkidx c%0d lane%0d got %0d want %0d", c, j, walk_ROB_idx_o[j*5 +: 5], shown[j]); else n_pass++;
            end
            if (rv) begin
                n_chk++; if (redirect_PC_o !== rpc) $display("FAIL rnd_pc c%0d got %h want %h", c, redirect_PC_o, rpc); else n_pass++;
            end
            tick();
            if (take) begin
                if (mode == 0) begin
                    q.delete();
                    for (int j = 0; j < best_age - 1; j++) q.push_back((int'(tail) - 1 - j + 64) % 32);
                end else begin
                    for (int j = 0; j < best_age - age_cur; j++) q.push_back((cul - j + 64) % 32);
                end
                cul = int'(req_idx[best*5 +: 5]); mpc = req_pc[best*64 +: 64]; age_cur = best_age;
                mode = (q.size() > 0) ? 1 : 2;
            end else if (mode == 1) begin
                mode = (q.size() > 0) ? 1 : 2;
            end else if (mode == 2 && rv && fetch_ready) begin
                mode = 0;
            end
            sq = take;
            if (take) sq_idx = cul;
            shown.delete();
            if (mode == 1)
                for (int j = 0; j < 2 && q.size() > 0; j++) shown.push_back(q.pop_front());
            rv = (mode == 2) && !take;
            if (rv) rpc = mpc;
        end
        clr_req(); fetch_ready = 1'b0;
    endtask

    initial begin
        reset_i = 1'b0; req_valid = '0; req_idx = '0; req_pc = '0; tail = '0; fetch_ready = 1'b0;
        test_reset();
        test_basic_walk();
        test_arbitration();
        test_wrap();
        test_preempt_walk();
        test_redirect_hold_preempt();
        test_no_walk_and_async_reset();
        test_full_rob();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
